// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared opcodes, FSM state and owner types for the SPI RAM arbiter
package spi_ram_pkg;
   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;
   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
   typedef enum logic {OWN_SPI, OWN_AUX} owner_t;
endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// rr_arb2: two-requester arbiter, bit 0 = SPI, bit 1 = aux; ARB_FIXED_PRIO_EN selects fixed SPI priority
module rr_arb2
   import spi_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);
`ifdef ARB_FIXED_PRIO_EN
   // SPI takes every tie; aux only wins when SPI is not asking
   always_comb gnt_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
`else
   owner_t last_q, last_d;
   // on a tie the requester that did not win last time is granted
   always_comb gnt_o = req_i[0] && (!req_i[1] || last_q == OWN_AUX) ? 2'b01 : {req_i[1], 1'b0};
   // remember the winner whenever a grant is actually taken
   always_comb last_d = advance_i && |gnt_o ? (gnt_o[1] ? OWN_AUX : OWN_SPI) : last_q;
   // last winner starts as aux so SPI takes the first tie
   always_ff @(posedge clk) begin
      if (rst) last_q <= OWN_AUX;
      else last_q <= last_d;
   end
`endif
endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one RAM port between the SPI command stream and an aux port (ARB_FIXED_PRIO_EN: fixed SPI priority)
module spi_ram_arbiter
   import spi_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [9:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  aux_req,
   input  logic                  aux_we,
   input  logic [ADDR_WIDTH-1:0] aux_addr,
   input  logic [DATA_WIDTH-1:0] aux_wdata,
   output logic                  aux_gnt,
   output logic [DATA_WIDTH-1:0] aux_rdata,
   output logic                  aux_rvalid,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  spi_ovf
);
   if (MEM_DEPTH != 2 ** ADDR_WIDTH) begin : g_depth_chk
      $error("MEM_DEPTH must equal 2**ADDR_WIDTH");
   end
   state_t                state_q, state_d;
   owner_t                owner_q, owner_d;
   logic [1:0]            op, gnt;
   logic [7:0]            payload;
   logic                  idle, grant_spi, grant_aux, enq, take, cap;
   logic [7:0]            wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic                  pend_q, pend_d, pend_we_q, pend_we_d;
   logic [7:0]            pend_addr_q, pend_addr_d, pend_data_q, pend_data_d;
   logic                  spi_ovf_q, spi_ovf_d;
   logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [DATA_WIDTH-1:0] aux_rdata_q, aux_rdata_d;
   logic                  aux_rvalid_q, aux_rvalid_d;

   assign op        = rx_data[9:8];
   assign payload   = rx_data[7:0];
   assign idle      = state_q == IDLE && !rst;
   assign grant_spi = idle && gnt[0];
   assign grant_aux = idle && gnt[1];
   assign enq       = rx_valid && (op == OP_WR_DATA || op == OP_RD_DATA);
   // the buffer frees in its own grant cycle, so a frame arriving then is accepted
   assign take      = enq && (!pend_q || grant_spi);
   assign cap       = state_q == CAPTURE;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     ({aux_req, pend_q}),
      .advance_i (idle),
      .gnt_o     (gnt)
   );

   // opcode decode, address registers, one-entry SPI buffer and sticky overflow
   always_comb begin
      wr_addr_d   = rx_valid && op == OP_WR_ADDR ? payload : wr_addr_q;
      rd_addr_d   = rx_valid && op == OP_RD_ADDR ? payload : rd_addr_q;
      pend_d      = take || (pend_q && !grant_spi);
      pend_we_d   = take ? op == OP_WR_DATA : pend_we_q;
      pend_addr_d = take ? (op == OP_WR_DATA ? wr_addr_q : rd_addr_q) : pend_addr_q;
      pend_data_d = take ? payload : pend_data_q;
      spi_ovf_d   = spi_ovf_q || (enq && !take);
   end

   // FSM next state: grant -> ACCESS, reads continue to CAPTURE, all return to IDLE
   always_comb begin
      state_d = state_q == IDLE ? (|gnt ? ACCESS : IDLE)
              : state_q == ACCESS && !ram_we_q ? CAPTURE : IDLE;
   end

   // FSM outputs: RAM command on grant, read data routed to the recorded owner in CAPTURE
   always_comb begin
      ram_en_d     = grant_spi || grant_aux;
      ram_we_d     = grant_spi ? pend_we_q : grant_aux && aux_we;
      ram_addr_d   = grant_spi ? ADDR_WIDTH'(pend_addr_q) : grant_aux ? aux_addr : ram_addr_q;
      ram_din_d    = grant_spi ? DATA_WIDTH'(pend_data_q) : grant_aux ? aux_wdata : ram_din_q;
      owner_d      = grant_spi ? OWN_SPI : grant_aux ? OWN_AUX : owner_q;
      tx_valid_d   = cap && owner_q == OWN_SPI;
      aux_rvalid_d = cap && owner_q == OWN_AUX;
      tx_data_d    = tx_valid_d ? 8'(ram_dout) : tx_data_q;
      aux_rdata_d  = aux_rvalid_d ? ram_dout : aux_rdata_q;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end

   // datapath registers; reset drops any in-flight access and the pending entry
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= OWN_SPI;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         pend_q       <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         spi_ovf_q    <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_din_q    <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         aux_rdata_q  <= '0;
         aux_rvalid_q <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         pend_q       <= pend_d;
         pend_we_q    <= pend_we_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         spi_ovf_q    <= spi_ovf_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         aux_rdata_q  <= aux_rdata_d;
         aux_rvalid_q <= aux_rvalid_d;
      end
   end

   assign aux_gnt    = grant_aux;
   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign aux_rdata  = aux_rdata_q;
   assign aux_rvalid = aux_rvalid_q;
   assign ram_en     = ram_en_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_din    = ram_din_q;
   assign spi_ovf    = spi_ovf_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed scoreboard bench for spi_ram_arbiter with a behavioural RAM
module tb_spi_ram_arbiter;
   logic       clk = 1'b0, rst = 1'b1;
   logic [9:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       aux_req = 1'b0, aux_we = 1'b0;
   logic [7:0] aux_addr = '0, aux_wdata = '0;
   logic       aux_gnt;
   logic [7:0] aux_rdata;
   logic       aux_rvalid;
   logic       ram_en, ram_we;
   logic [7:0] ram_addr, ram_din;
   logic [7:0] ram_dout = '0;
   logic       spi_ovf;
   logic [7:0] mem [256];
   logic [7:0] exp_tx[$], exp_aux[$];
   int         tx_t[$], aux_t[$];
   int         n_cmp = 0, n_bad = 0, cyc = 0, gnt_cnt = 0;
   int         c0, g0, ga;
`ifdef ARB_FIXED_PRIO_EN
   localparam int EXP_GA = 7, EXP_TX1 = 7, EXP_AUX0 = 10;
`else
   localparam int EXP_GA = 4, EXP_TX1 = 10, EXP_AUX0 = 7;
`endif

   spi_ram_arbiter dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .spi_ovf(spi_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else ram_dout <= mem[ram_addr];
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard whenever the DUT strobes read data
   always @(negedge clk) begin
      if (tx_valid) begin
         tx_t.push_back(cyc);
         if (exp_tx.size() == 0) chk("tx_unexpected_strobe", tx_valid, 0);
         else chk("tx_data", tx_data, exp_tx.pop_front());
      end
      if (aux_rvalid) begin
         aux_t.push_back(cyc);
         if (exp_aux.size() == 0) chk("aux_unexpected_strobe", aux_rvalid, 0);
         else chk("aux_rdata", aux_rdata, exp_aux.pop_front());
      end
      if (aux_gnt) gnt_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic spi(input logic [1:0] op, input logic [7:0] pl);
      rx_data = {op, pl};
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic aux_do(input logic we, input logic [7:0] a, input logic [7:0] d, input logic [7:0] e);
      aux_req = 1'b1;
      aux_we = we;
      aux_addr = a;
      aux_wdata = d;
      if (!we) exp_aux.push_back(e);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (aux_gnt) break;
      end
      chk("aux_gnt_seen", aux_gnt, 1);
      tick();
      aux_req = 1'b0;
   endtask

   task automatic drain;
      for (int k = 0; k < 60 && (exp_tx.size() != 0 || exp_aux.size() != 0); k++) tick();
      chk("drain_tx_left", exp_tx.size(), 0);
      chk("drain_aux_left", exp_aux.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_aux_gnt", aux_gnt, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_spi_ovf", spi_ovf, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_ram_addr", ram_addr, 0);
      tick();
      rst = 1'b0;
      // basic SPI write then read back with exact strobe slot
      spi(2'b00, 8'h2A);
      spi(2'b01, 8'h5C);
      spi(2'b10, 8'h2A);
      exp_tx.push_back(8'h5C);
      spi(2'b11, 8'h00);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t1_tx_valid_slot", tx_valid, int'(k == 3));
      end
      tick();
      drain();
      chk("t1_ram_2a", mem[8'h2A], 8'h5C);
      // aux writes, read back over SPI
      g0 = gnt_cnt;
      aux_do(1'b1, 8'h10, 8'hA5, 8'h00);
      tick();
      tick();
      chk("t2_aux_gnt_once", gnt_cnt - g0, 1);
      aux_do(1'b1, 8'h00, 8'h3C, 8'h00);
      spi(2'b10, 8'h10);
      exp_tx.push_back(8'hA5);
      spi(2'b11, 8'h00);
      drain();
      chk("t2_ram_00", mem[8'h00], 8'h3C);
      // ties from reset: SPI first, then the repeated tie
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tx_t.delete();
      aux_t.delete();
      c0 = cyc;
      exp_tx.push_back(8'h3C);
      exp_tx.push_back(8'h5C);
      exp_aux.push_back(8'hA5);
      spi(2'b11, 8'h00);
      aux_req = 1'b1;
      aux_we = 1'b0;
      aux_addr = 8'h10;
      @(negedge clk);
      chk("t3_tie1_spi_first", aux_gnt, 0);
      tick();
      spi(2'b10, 8'h2A);
      spi(2'b11, 8'h00);
      ga = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (aux_gnt) begin
            ga = cyc - c0;
            break;
         end
      end
      chk("t3_aux_grant_cycle", ga, EXP_GA);
      tick();
      aux_req = 1'b0;
      drain();
      chk("t3_tx_strobes", tx_t.size(), 2);
      chk("t3_aux_strobes", aux_t.size(), 1);
      if (tx_t.size() == 2 && aux_t.size() == 1) begin
         chk("t3_tx0_cycle", tx_t[0] - c0, 4);
         chk("t3_tx1_cycle", tx_t[1] - c0, EXP_TX1);
         chk("t3_aux0_cycle", aux_t[0] - c0, EXP_AUX0);
      end
      // overflow while aux owns the RAM
      chk("t4_ovf_clear", spi_ovf, 0);
      spi(2'b00, 8'h40);
      aux_do(1'b0, 8'h10, 8'h00, 8'hA5);
      spi(2'b01, 8'h11);
      spi(2'b01, 8'h22);
      @(negedge clk);
      chk("t4_ovf_set", spi_ovf, 1);
      tick();
      drain();
      repeat (4) tick();
      chk("t4_ovf_sticky", spi_ovf, 1);
      chk("t4_ram_40", mem[8'h40], 8'h11);
      // reset during CAPTURE of an SPI read
      spi(2'b11, 8'h00);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_tx_valid", tx_valid, 0);
      chk("t5_ram_en", ram_en, 0);
      chk("t5_spi_ovf", spi_ovf, 0);
      repeat (4) tick();
      spi(2'b01, 8'h77);
      exp_tx.push_back(8'h77);
      spi(2'b11, 8'h00);
      drain();
      chk("t5_ram_00", mem[8'h00], 8'h77);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
